// File: rtl/display_pkg.sv
// Character codes, segment patterns and the message ROM shared by the
// front-panel message scanner.
package display_pkg;

  localparam int CHAR_W   = 5;
  localparam int SEG_W    = 7;
  localparam int MSG_LEN  = 4;
  localparam int ROM_MSGS = 8;

  localparam logic [CHAR_W-1:0] CH_0     = 5'd0;
  localparam logic [CHAR_W-1:0] CH_1     = 5'd1;
  localparam logic [CHAR_W-1:0] CH_2     = 5'd2;
  localparam logic [CHAR_W-1:0] CH_3     = 5'd3;
  localparam logic [CHAR_W-1:0] CH_4     = 5'd4;
  localparam logic [CHAR_W-1:0] CH_5     = 5'd5;
  localparam logic [CHAR_W-1:0] CH_6     = 5'd6;
  localparam logic [CHAR_W-1:0] CH_7     = 5'd7;
  localparam logic [CHAR_W-1:0] CH_8     = 5'd8;
  localparam logic [CHAR_W-1:0] CH_9     = 5'd9;
  localparam logic [CHAR_W-1:0] CH_C     = 5'd10;
  localparam logic [CHAR_W-1:0] CH_L     = 5'd11;
  localparam logic [CHAR_W-1:0] CH_A     = 5'd12;
  localparam logic [CHAR_W-1:0] CH_F     = 5'd13;
  localparam logic [CHAR_W-1:0] CH_E     = 5'd14;
  localparam logic [CHAR_W-1:0] CH_P     = 5'd15;
  localparam logic [CHAR_W-1:0] CH_R     = 5'd16;
  localparam logic [CHAR_W-1:0] CH_N     = 5'd17;
  localparam logic [CHAR_W-1:0] CH_U     = 5'd18;
  localparam logic [CHAR_W-1:0] CH_BLANK = 5'd31;

  // Segment order is {a,b,c,d,e,f,g}, active-high.
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b1001110;
  localparam logic [SEG_W-1:0] SEG_L     = 7'b0001110;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b1110111;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b1000111;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_P     = 7'b1100111;
  localparam logic [SEG_W-1:0] SEG_R     = 7'b0000101;
  localparam logic [SEG_W-1:0] SEG_N     = 7'b0010101;
  localparam logic [SEG_W-1:0] SEG_U     = 7'b0111110;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  // One row per machine state, leftmost character first.
  localparam logic [CHAR_W-1:0] MSG_ROM [0:ROM_MSGS-1][0:MSG_LEN-1] = '{
    '{CH_C, CH_A, CH_F, CH_E},     // S0 "CAFE"
    '{CH_C, CH_L, CH_0, CH_2},     // S1 "CL02"
    '{CH_C, CH_L, CH_0, CH_5},     // S2 "CL05"
    '{CH_C, CH_L, CH_1, CH_0},     // S3 "CL10"
    '{CH_E, CH_R, CH_R, CH_BLANK}, // SR "Err "
    '{CH_P, CH_R, CH_E, CH_P},     // SP "PrEP"
    '{CH_N, CH_U, CH_L, CH_L},     // SN "nULL"
    '{CH_U, CH_A, CH_L, CH_1}      // VL "UAL1"
  };

endpackage

// File: rtl/char_to_seg.sv
// Combinational character-code to 7-segment decoder; unknown codes are blank.
module char_to_seg
  import display_pkg::*;
(
  input  logic [CHAR_W-1:0] code_i,
  output logic [SEG_W-1:0]  seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (code_i)
      CH_0:    seg_o = SEG_0;
      CH_1:    seg_o = SEG_1;
      CH_2:    seg_o = SEG_2;
      CH_3:    seg_o = SEG_3;
      CH_4:    seg_o = SEG_4;
      CH_5:    seg_o = SEG_5;
      CH_6:    seg_o = SEG_6;
      CH_7:    seg_o = SEG_7;
      CH_8:    seg_o = SEG_8;
      CH_9:    seg_o = SEG_9;
      CH_C:    seg_o = SEG_C;
      CH_L:    seg_o = SEG_L;
      CH_A:    seg_o = SEG_A;
      CH_F:    seg_o = SEG_F;
      CH_E:    seg_o = SEG_E;
      CH_P:    seg_o = SEG_P;
      CH_R:    seg_o = SEG_R;
      CH_N:    seg_o = SEG_N;
      CH_U:    seg_o = SEG_U;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_mensagem_scan.sv
// Time-multiplexed 7-segment message driver: prescaled digit scan, per-frame
// message latch from a one-hot state vector, blink and invalid-state blanking.
module display_mensagem_scan
  import display_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int N_MSGS    = 8,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_MSGS-1:0]   estado,
  input  logic                blink,
  output logic [6:0]          seg,
  output logic [N_DIGITS-1:0] digit_en,
  output logic                frame_tick
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int MSG_W = $clog2(N_MSGS);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BLK_W-1:0]    blk_cnt_q, blk_cnt_d;
  logic                hidden_q, hidden_d;
  logic [MSG_W-1:0]    msg_q, msg_d;
  logic                msg_ok_q, msg_ok_d;
  logic                first_q;
  logic [SEG_W-1:0]    seg_q, seg_d;
  logic [N_DIGITS-1:0] den_q, den_d;
  logic                ftick_q, ftick_d;

  logic                slot_end, frame_end, latch_now;
  logic                hot_ok;
  logic [MSG_W-1:0]    hot_idx;
  logic [MSG_W-1:0]    msg_eff;
  logic                msg_ok_eff;
  logic [CHAR_W-1:0]   char_code;
  logic [SEG_W-1:0]    char_seg;

  // Exactly-one-hot test plus the position of the (last) set bit.
  always_comb begin
    hot_ok  = (estado != '0) && ((estado & (estado - N_MSGS'(1))) == '0);
    hot_idx = '0;
    for (int i = 0; i < N_MSGS; i++) begin
      if (estado[i]) hot_idx = MSG_W'(i);
    end
  end

  always_comb begin
    slot_end  = (presc_q == PRE_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);
    latch_now = first_q || frame_end;

    presc_d = slot_end ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    msg_d    = msg_q;
    msg_ok_d = msg_ok_q;
    if (latch_now) begin
      msg_d    = hot_idx;
      msg_ok_d = hot_ok;
    end

    // With blink off the phase is pinned visible so a later enable starts clean.
    blk_cnt_d = blk_cnt_q;
    hidden_d  = hidden_q;
    if (!blink) begin
      blk_cnt_d = '0;
      hidden_d  = 1'b0;
    end else if (frame_end) begin
      if (blk_cnt_q == BLK_LAST) begin
        blk_cnt_d = '0;
        hidden_d  = ~hidden_q;
      end else begin
        blk_cnt_d = blk_cnt_q + 1'b1;
      end
    end
  end

  // The first post-reset cycle renders from the value being latched, so the
  // first slot is not blank for one cycle.
  always_comb begin
    msg_eff    = first_q ? hot_idx : msg_q;
    msg_ok_eff = first_q ? hot_ok  : msg_ok_q;
    char_code  = CH_BLANK;
    if ((int'(idx_q) < MSG_LEN) && (int'(msg_eff) < ROM_MSGS)) begin
      char_code = MSG_ROM[3'(msg_eff)][2'(idx_q)];
    end
  end

  char_to_seg u_char_to_seg (
    .code_i (char_code),
    .seg_o  (char_seg)
  );

  always_comb begin
    den_d = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      den_d[i] = (int'(idx_q) == i);
    end
    seg_d   = (msg_ok_eff && !(blink && hidden_q)) ? char_seg : SEG_BLANK;
    ftick_d = frame_end;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q   <= '0;
      idx_q     <= '0;
      blk_cnt_q <= '0;
      hidden_q  <= 1'b0;
      msg_q     <= '0;
      msg_ok_q  <= 1'b0;
      first_q   <= 1'b1;
      seg_q     <= '0;
      den_q     <= '0;
      ftick_q   <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      blk_cnt_q <= blk_cnt_d;
      hidden_q  <= hidden_d;
      msg_q     <= msg_d;
      msg_ok_q  <= msg_ok_d;
      first_q   <= 1'b0;
      seg_q     <= seg_d;
      den_q     <= den_d;
      ftick_q   <= ftick_d;
    end
  end

  assign seg        = seg_q;
  assign digit_en   = den_q;
  assign frame_tick = ftick_q;

endmodule

// File: doc/display_mensagem_scan.md
Name: display_mensagem_scan

Overview:
- Parametrised, time-multiplexed 7-segment message driver for the coffee-machine front panel.
- Scans N_DIGITS characters onto a shared segment bus with its own prescaled scan counter; no external counter is needed.
- Selects the message from the one-hot machine-state vector (S0..S3, SR, SP, SN, VL).
- Adds blink mode, blanking on invalid state, and glitch-free message changes.

Parameters:
- N_DIGITS, 4, number of multiplexed digits (2..8).
- N_MSGS, 8, number of machine states / messages (one-hot width).
- SCAN_DIV, 50000, clock cycles per digit slot (>=2).
- BLINK_DIV, 64, digit-scan frames per blink half-period (>=1).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- estado  in  N_MSGS  one-hot machine state; bit0=S0, bit1=S1, bit2=S2, bit3=S3, bit4=SR, bit5=SP, bit6=SN, bit7=VL
- blink  in  1  1 = message flashes at the blink rate
- seg  out  7  segments {a,b,c,d,e,f,g}, seg[6]=a, active-high
- digit_en  out  N_DIGITS  one-hot digit enable; bit0 = leftmost digit
- frame_tick  out  1  one-cycle pulse when the last digit slot ends

Behaviour:
- Reset: seg=0, digit_en=0, frame_tick=0, prescaler=0, digit index=0, blink phase=visible, latched message=invalid.
- Prescaler counts 0..SCAN_DIV-1. At the terminal count the digit index advances and wraps from N_DIGITS-1 to 0.
- frame_tick is asserted in the same cycle the index wraps to 0.
- Blink counter counts frame_ticks 0..BLINK_DIV-1. At its terminal count the blink phase toggles.
- Outputs are registered. seg and digit_en reflect the current index one cycle after the index register updates.
- There is never a cycle in which digit_en has more than one bit set.
- Message latch: estado is sampled at every frame boundary (index wrap) and on the first cycle after reset. A message never changes mid-frame.
  - exactly one bit set: latch that message index.
  - zero bits or more than one bit set: latch "invalid". All digits show blank (seg=0); digit_en keeps scanning.
- Blank conditions: seg=0 when blink=1 and the phase is hidden. When blink=0, the phase is forced visible and the blink counter is held at 0.
- Character lookup: message ROM[msg][digit] gives a 5-bit char code; char code maps to a 7-bit segment pattern. Unknown codes produce blank.
- Reset mid-frame: all state returns to reset values on the next edge. The first digit slot after reset is digit 0.
- N_DIGITS larger than the stored message length: the extra digits show blank.

Decomposition:
- Package display_pkg holds:
  - char-code localparams (digits 0-9; C, L, A, F, E, P, r, n, U; BLANK=31)
  - the 7-bit segment constants per char code
  - MSG_LEN=4
  - the message ROM constant (N_MSGS x MSG_LEN char codes). S1 entry is "CL02"; the other entries are defined in the package.
- One sub-module: char_to_seg (combinational, 5-bit code in, 7-bit seg out).
- Counters, message latch, blink logic and output registers stay in the top module.

Test Plan:
- Run with SCAN_DIV=4. Hold reset 3 cycles, then set estado=8'b0000_0010, blink=0. Over one frame, digit_en steps through 0001, 0010, 0100, 1000 with 4 cycles per slot. seg in each slot is 1001110 (C), 0001110 (L), 1111110 (0), 1101101 (2). frame_tick is one cycle wide every 16 cycles.
- Change estado from S1 to another state mid-frame at slot 2. The remaining slots of that frame still show "CL02" ("0" then "2"). The new message appears from digit 0 of the next frame.
- Set estado=8'b0000_0110 (two hot bits) and, in a separate test, estado=0. After the next frame boundary, seg=0 in all slots while digit_en keeps cycling normally.
- Run with BLINK_DIV=2 and blink=1. The pattern is 2 visible frames, then 2 frames with seg=0, and so on. Drop blink to 0 while hidden: seg is visible again starting from the next slot.
- Assert reset during slot 2 for 1 cycle. The next cycle has seg=0 and digit_en=0. Scanning restarts at digit 0 with the prescaler at 0.
- Run with N_DIGITS=6. digit_en cycles through 6 one-hot values. Slots 4 and 5 show seg=0. A 6-slot frame_tick period is verified.
